// File: rtl/gradient_pkg.sv
// Shared constants and state encoding for the gradient window sequencer.
package gradient_pkg;

    localparam int PIX_W       = 24;
    localparam int NPIX        = 9;
    localparam int WIN_W       = NPIX * PIX_W;
    localparam int TIMEOUT_CYC = 64;
    localparam int CLR_CYC     = 1;
    localparam int CNT_W       = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2,
        CLR  = 2'd3
    } state_t;

endpackage

// File: rtl/gradient_window_sequencer_counter.sv
// Loadable up/down cycle counter with a terminal-count compare, shared by the
// RUN timeout and the CLR hold count.
module seq_cycle_counter #(
    parameter int             W       = 6,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         Clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_up,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every reader sees the pre-edge value regardless of block ordering.
    always_ff @(posedge Clock) begin
        if (reset) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= i_up ? r_count + W'(1) : r_count - W'(1);
        end
    end

    assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/gradient_window_sequencer.sv
// Sequences 3x3 windows through the matrix_mult gradient engine with a done
// timeout. Optional perf counters are enabled by defining GRAD_SEQ_PERF_CNT_EN.
module gradient_window_sequencer
    import gradient_pkg::*;
(
    input  logic             Clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIN_W-1:0] in_win,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIN_W-1:0] out_gm,
    output logic             out_timeout,
    output logic [WIN_W-1:0] eng_A,
    output logic             eng_Enable,
    output logic             eng_reset,
    input  logic             eng_done,
    input  logic [WIN_W-1:0] eng_GM,
    output logic             busy
`ifdef GRAD_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]      win_count,
    output logic [15:0]      timeout_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_CLR  = CNT_W'(CLR_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    logic [WIN_W-1:0] r_eng_a;
    logic             r_eng_enable;
    logic             r_eng_reset;
    logic             r_out_valid;
    logic             r_out_timeout;
    logic [WIN_W-1:0] r_out_gm;
    logic             r_busy;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_en;
    logic             w_cnt_up;
    logic [CNT_W-1:0] w_cnt_tc_val;
    logic             w_cnt_tc;
    logic             w_out_fire;

    assign w_out_fire = (r_state == OUT) && out_ready;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = CNT_ZERO;
        w_cnt_en       = 1'b0;
        w_cnt_up       = 1'b0;
        w_cnt_tc_val   = CNT_TMO;
        case (r_state)
            IDLE: begin
                w_cnt_load = in_valid;
            end
            RUN: begin
                w_cnt_en = 1'b1;
                w_cnt_up = 1'b1;
            end
            OUT: begin
                w_cnt_load     = out_ready;
                w_cnt_load_val = CNT_CLR;
            end
            CLR: begin
                w_cnt_en     = 1'b1;
                w_cnt_tc_val = CNT_ONE;
            end
            default: ;
        endcase
    end

    seq_cycle_counter #(
        .W       (CNT_W),
        .RST_VAL (CNT_CLR)
    ) u_cnt (
        .Clock      (Clock),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .i_up       (w_cnt_up),
        .i_tc_val   (w_cnt_tc_val),
        .o_tc       (w_cnt_tc)
    );

    // Reset lands in CLR so the engine is cleared before the first window.
    always_ff @(posedge Clock) begin
        if (reset) begin
            r_state       <= CLR;
            r_eng_a       <= '0;
            r_eng_enable  <= 1'b0;
            r_eng_reset   <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_timeout <= 1'b0;
            r_out_gm      <= '0;
            r_busy        <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_eng_a      <= in_win;
                        r_eng_enable <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        r_out_gm      <= eng_GM;
                        r_out_timeout <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_eng_enable  <= 1'b0;
                        r_state       <= OUT;
                    end else if (w_cnt_tc) begin
                        r_out_gm      <= '0;
                        r_out_timeout <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_eng_enable  <= 1'b0;
                        r_state       <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid   <= 1'b0;
                        r_out_timeout <= 1'b0;
                        r_eng_reset   <= 1'b1;
                        r_state       <= CLR;
                    end
                end
                CLR: begin
                    if (w_cnt_tc) begin
                        r_eng_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= CLR;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign out_gm      = r_out_gm;
    assign out_timeout = r_out_timeout;
    assign eng_A       = r_eng_a;
    assign eng_Enable  = r_eng_enable;
    assign eng_reset   = r_eng_reset;
    assign busy        = r_busy;

`ifdef GRAD_SEQ_PERF_CNT_EN
    logic [15:0] r_win_count;
    logic [15:0] r_timeout_count;

    always_ff @(posedge Clock) begin
        if (reset) begin
            r_win_count     <= '0;
            r_timeout_count <= '0;
        end else if (w_out_fire) begin
            if (r_out_timeout) begin
                if (r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 16'd1;
            end else begin
                if (r_win_count != 16'hFFFF) r_win_count <= r_win_count + 16'd1;
            end
        end
    end

    assign win_count     = r_win_count;
    assign timeout_count = r_timeout_count;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_out_fire;
`endif

endmodule
